relay_image_seq: RTL and testbench
==================================

// Module: relay_image_seq
// PURPOSE
// - Upstream stage of the TPIC serializer: holds the relay image and drives its parallel data word.
// - Host writes bytes into a shadow register; a commit applies the image with break-before-make sequencing.
// - Sequencing: drop opening relays, wait until the serializer has latched that pattern, settle, then close new relays.
// - Frame progress is taken from the serializer's rck pulse (one clk wide, same clock domain).
// PARAMETERS
// - WIDTH          16   relay image width; multiple of 8; equals serializer WIDTH
// - SETTLE_CYCLES  1000 clk cycles of mechanical settle between break and make; must be >=1
// - WDOG_CYCLES    2**24 idle cycles without commit before watchdog trip (RLY_WDOG_EN only)
// PORTS
// - clk          in   1                 system clock, rising edge
// - reset        in   1                 asynchronous, active-high
// - wr_valid     in   1                 byte write request
// - wr_ready     out  1                 1 when state==IDLE; write occurs on wr_valid&wr_ready
// - wr_addr      in   $clog2(WIDTH/8)   byte index; byte k = bits [8k+7:8k]
// - wr_data      in   8                 byte value
// - commit       in   1                 one-cycle pulse: apply shadow image
// - rck          in   1                 serializer latch strobe (frame complete)
// - data_out     out  WIDTH             word to serializer data input
// - active       out  WIDTH             last fully applied image
// - busy         out  1                 1 in any state other than IDLE
// - done         out  1                 one-cycle pulse when sequence completes
// - commit_err   out  1                 one-cycle pulse: commit while busy (ignored)
// - wdog_trip    out  1                 one-cycle pulse on watchdog trip (RLY_WDOG_EN only)
// BEHAVIOUR
// - Reset: shadow=0, target=0, active=0, data_out=0, busy=0, done=0, commit_err=0, wdog_trip=0, state=IDLE.
// - Reset mid-sequence: immediate return to reset values; no done pulse.
// - Writes accepted only in IDLE: shadow byte wr_addr <= wr_data; wr_addr >= WIDTH/8 is accepted and dropped.
// - Write and commit in same IDLE cycle: commit snapshots shadow including that write.
// - Commit in IDLE: target <= shadow; off_mask = active & ~target.
//   - off_mask != 0 -> BREAK; off_mask == 0 -> MAKE (no break phase).
// - Commit while busy: ignored, commit_err=1 for 1 cycle; shadow/target unchanged.
// - FSM (frame count resets to 0 on state entry):
//   - IDLE:   data_out = active.
//   - BREAK:  data_out = active & target; count rck pulses; at 2nd pulse -> SETTLE.
//     (2 pulses needed: 1st may close a frame sampled before the change.)
//   - SETTLE: data_out held; down-counter from SETTLE_CYCLES; at 0 -> MAKE.
//   - MAKE:   data_out = target; count rck pulses; at 2nd pulse -> DONE.
//   - DONE:   active <= target; done=1 one cycle -> IDLE.
// - data_out is registered; it updates the cycle after entering BREAK/MAKE and is stable within a state.
// - rck coinciding with the state-entry cycle is not counted.
// - Latency, commit to done, with serializer frame F = 2*WIDTH+2 clk:
//   - with break: <= 4F + SETTLE_CYCLES + 3
//   - make only:  <= 2F + 2
// - Commit with target == active: MAKE only, done still pulses.
// CONFIGURATION
// - RLY_WDOG_EN defined:
//   - 24-bit idle counter, cleared on every accepted commit and while busy.
//   - Reaches WDOG_CYCLES in IDLE: shadow <= 0, internal commit of all-zero image, wdog_trip=1 for 1 cycle.
//   - Host commit in the same cycle as trip wins; no trip, counter cleared.
// - RLY_WDOG_EN undefined: no counter, no wdog_trip port; image held indefinitely.
// TESTING (WIDTH=16, SETTLE_CYCLES=4, rck modelled every 34 clk or by serializer instance)
// - Reset, write bytes 0x0F/0x00, commit -> MAKE only; data_out=0x000F after 1 clk; done after 2 rck; active=0x000F.
// - active=0x00FF, write 0x0F to byte0 and 0xF0 to byte1, commit:
//   - data_out=0x000F in BREAK; 0xF00F after 2 rck + 4 clk; done after 2 more rck.
// - Commit during BREAK -> commit_err pulse; sequence and target unchanged; wr_ready=0 and writes ignored.
// - Write byte1=0xAA with commit same cycle, active=0 -> target=0xAA00, make-only path.
// - Assert reset in SETTLE -> data_out=0, active=0, busy=0 next cycle; no done pulse.
// - RLY_WDOG_EN, WDOG_CYCLES=100, active=0x0003 -> wdog_trip at idle cycle 100; BREAK to 0x0000; done; active=0.

Source files
------------

// File: rtl/relay_image_seq.sv
// Relay image holder: host bytes go to a shadow register, commit applies them break-before-make
// into the serializer data word. Define RLY_WDOG_EN to add the idle watchdog and wdog_trip port.
module relay_image_seq #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1000
`ifdef RLY_WDOG_EN
  ,
  parameter int WDOG_CYCLES   = 2**24
`endif
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           wr_valid,
  output logic                                           wr_ready,
  input  logic [(WIDTH > 8 ? $clog2(WIDTH/8) : 1)-1:0]   wr_addr,
  input  logic [7:0]                                     wr_data,
  input  logic                                           commit,
  input  logic                                           rck,
  output logic [WIDTH-1:0]                               data_out,
  output logic [WIDTH-1:0]                               active,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           commit_err
`ifdef RLY_WDOG_EN
  ,
  output logic                                           wdog_trip
`endif
);

  localparam int NBYTES = WIDTH / 8;
  localparam int SW     = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_SETTLE,
    S_MAKE,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shadow, shadow_nxt, target, new_target;
  logic             fresh;       // first cycle in the current state
  logic             frame_cnt;   // one counted rck already seen in BREAK/MAKE
  logic [SW-1:0]    settle_cnt;
  logic             counted;
  logic             trip;

`ifdef RLY_WDOG_EN
  logic [23:0]      idle_cnt;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    next_state = state;
    shadow_nxt = shadow;
    trip       = 1'b0;
    counted    = rck && !fresh;   // an rck in the entry cycle may close a frame of the old word

    if (state == S_IDLE && wr_valid && int'(wr_addr) < NBYTES)
      shadow_nxt[8*wr_addr +: 8] = wr_data;

`ifdef RLY_WDOG_EN
    trip = (state == S_IDLE) && !commit && (idle_cnt == 24'(WDOG_CYCLES - 1));
    if (trip) shadow_nxt = '0;
`endif

    new_target = shadow_nxt;

    case (state)
      S_IDLE:   if (commit || trip)
                  next_state = ((active & ~new_target) != '0) ? S_BREAK : S_MAKE;
      S_BREAK:  if (counted && frame_cnt) next_state = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) next_state = S_MAKE;
      S_MAKE:   if (counted && frame_cnt) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign wr_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign commit_err = commit && busy;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fresh      <= 1'b0;
      frame_cnt  <= 1'b0;
      settle_cnt <= '0;
      shadow     <= '0;
      target     <= '0;
      active     <= '0;
      data_out   <= '0;
    end else begin
      state  <= next_state;
      fresh  <= (next_state != state);
      shadow <= shadow_nxt;

      if (state == S_IDLE && (commit || trip)) target <= new_target;
      if (state == S_DONE) active <= target;

      if (next_state != state)
        frame_cnt <= 1'b0;
      else if (counted && (state == S_BREAK || state == S_MAKE))
        frame_cnt <= 1'b1;

      if (next_state == S_SETTLE && state != S_SETTLE)
        settle_cnt <= SW'(SETTLE_CYCLES - 1);
      else if (state == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;

      // Word follows the state one cycle late and is held through SETTLE and DONE.
      case (state)
        S_IDLE:  data_out <= active;
        S_BREAK: data_out <= active & target;
        S_MAKE:  data_out <= target;
        default: ;
      endcase
    end
  end

`ifdef RLY_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (state != S_IDLE || commit || trip)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign wdog_trip = trip;
`endif

endmodule

// File: tb/tb_relay_image_seq.sv
// Bench for relay_image_seq: directed scenarios plus $urandom traffic, every cycle compared
// against a phase-level reference model of the break/settle/make sequence.
module tb_relay_image_seq;

  localparam int W = 16;
  localparam int S = 4;
  localparam int F = 2*W + 2;
`ifdef RLY_WDOG_EN
  localparam int WD = 100;
`endif
  localparam int P_IDLE = 0, P_BREAK = 1, P_SETTLE = 2, P_MAKE = 3, P_DONE = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [0:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         commit = 1'b0;
  logic         rck = 1'b0;
  logic [W-1:0] data_out, active;
  logic         busy, done, commit_err;
`ifdef RLY_WDOG_EN
  logic         wdog_trip;
`endif

  always #5 clk = ~clk;

  relay_image_seq #(
    .WIDTH(W),
    .SETTLE_CYCLES(S)
`ifdef RLY_WDOG_EN
    , .WDOG_CYCLES(WD)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .rck(rck),
    .data_out(data_out),
    .active(active),
    .busy(busy),
    .done(done),
`ifdef RLY_WDOG_EN
    .wdog_trip(wdog_trip),
`endif
    .commit_err(commit_err)
  );

  int n_cmp = 0, n_bad = 0;
  int rck_ph = 0;
  int dut_done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase, cycles spent in phase, frame strobes seen in phase.
  int           m_ph = P_IDLE, m_age = 0, m_seen = 0, m_idle = 0;
  logic [W-1:0] m_shadow = '0, m_target = '0, m_active = '0, m_dout = '0;

  task automatic enter(input int p);
    m_ph = p; m_age = 0; m_seen = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] sh;
    logic         trip;
    sh   = m_shadow;
    trip = 1'b0;
    if (m_ph == P_IDLE && wr_valid) sh[8*wr_addr +: 8] = wr_data;
`ifdef RLY_WDOG_EN
    trip = (m_ph == P_IDLE) && !commit && (m_idle == WD - 1);
    if (m_ph == P_IDLE && !commit && !trip) m_idle++;
    else m_idle = 0;
    if (trip) sh = '0;
`endif
    if (m_ph == P_IDLE)       m_dout = m_active;
    else if (m_ph == P_BREAK) m_dout = m_active & m_target;
    else if (m_ph == P_MAKE)  m_dout = m_target;
    m_shadow = sh;
    case (m_ph)
      P_IDLE:
        if (commit || trip) begin
          m_target = sh;
          enter(((m_active & ~sh) != '0) ? P_BREAK : P_MAKE);
        end else m_age++;
      P_BREAK, P_MAKE: begin
        if (rck && m_age > 0) m_seen++;
        if (m_seen == 2) enter(m_ph == P_BREAK ? P_SETTLE : P_DONE);
        else m_age++;
      end
      P_SETTLE:
        if (m_age == S - 1) enter(P_MAKE);
        else m_age++;
      default: begin
        m_active = m_target;
        enter(P_IDLE);
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      enter(P_IDLE);
      m_idle = 0; m_shadow = '0; m_target = '0; m_active = '0; m_dout = '0;
    end else model_step();
  end

  // One clock of stimulus, then compare every output against the model.
  task automatic cyc(input logic rst, input logic wv, input logic [0:0] wa,
                     input logic [7:0] wd, input logic cm);
    @(negedge clk);
    reset = rst; wr_valid = wv; wr_addr = wa; wr_data = wd; commit = cm;
    rck    = (rck_ph == 0);
    rck_ph = (rck_ph + 1) % F;
    #1;
    if (done === 1'b1) dut_done_cnt++;
    check("wr_ready",   wr_ready,   m_ph == P_IDLE);
    check("busy",       busy,       m_ph != P_IDLE);
    check("done",       done,       m_ph == P_DONE);
    check("commit_err", commit_err, cm && m_ph != P_IDLE);
    check("data_out",   data_out,   m_dout);
    check("active",     active,     m_active);
`ifdef RLY_WDOG_EN
    check("wdog_trip",  wdog_trip,  !rst && m_ph == P_IDLE && !cm && m_idle == WD - 1);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [0:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic do_commit();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < bound) begin
      idle(1);
      lat++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int base;
    rck_ph = $urandom_range(F - 1);

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_active", active, '0);
    check("rst_busy", busy, 1'b0);
    idle(2);

    // Make-only commit from an all-open image.
    wr(1'b0, 8'h0F); wr(1'b1, 8'h00); do_commit();
    idle(2);
    check("mk_data_out", data_out, 16'h000F);
    wait_done(2*F + 2, lat);
    check("mk_latency", (lat + 2) <= (2*F + 2), 1'b1);
    idle(1);
    check("mk_active", active, 16'h000F);

    // Break-before-make: 0x00FF -> 0xF00F.
    wr(1'b0, 8'hFF); do_commit(); wait_done(2*F + 2, lat); idle(1);
    check("pre_active", active, 16'h00FF);
    wr(1'b0, 8'h0F); wr(1'b1, 8'hF0); do_commit();
    idle(2);
    check("brk_data_out", data_out, 16'h000F);
    wait_done(4*F + S + 3, lat);
    check("brk_latency", (lat + 2) <= (4*F + S + 3), 1'b1);
    idle(1);
    check("brk_active", active, 16'hF00F);

    // Commit while busy is rejected and its write is dropped.
    wr(1'b0, 8'h00); wr(1'b1, 8'h00); do_commit();
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 8'h55, 1'b1);
    check("busy_commit_err", commit_err, 1'b1);
    check("busy_wr_ready", wr_ready, 1'b0);
    wait_done(4*F + S + 3, lat); idle(1);
    check("busy_active", active, 16'h0000);

    // Write and commit in the same cycle.
    cyc(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1);
    wait_done(2*F + 2, lat);
    check("same_cyc_latency", lat <= (2*F + 2), 1'b1);
    idle(1);
    check("same_cyc_active", active, 16'hAA00);

    // Reset asserted during SETTLE.
    wr(1'b1, 8'h00); do_commit();
    for (int i = 0; i < 4*F && m_ph != P_SETTLE; i++) idle(1);
    check("reach_settle", m_ph == P_SETTLE, 1'b1);
    base = dut_done_cnt;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_settle_data_out", data_out, '0);
    check("rst_settle_active", active, '0);
    check("rst_settle_busy", busy, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(3*F);
    check("rst_settle_no_done", dut_done_cnt, base);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit idl;
      idl = (m_ph == P_IDLE);
      if ($urandom_range(499) == 0) rck_ph = $urandom_range(F - 1);
      cyc($urandom_range(2999) == 0,
          $urandom_range(idl ? 2 : 9) == 0,
          1'($urandom_range(1)),
          8'($urandom),
          $urandom_range(idl ? 25 : 120) == 0);
    end
    for (int i = 0; i < 6*F && m_ph != P_IDLE; i++) idle(1);
    check("rand_settled", m_ph == P_IDLE, 1'b1);

`ifdef RLY_WDOG_EN
    begin
      int k;
      wr(1'b0, 8'h03); wr(1'b1, 8'h00); do_commit();
      wait_done(4*F + S + 3, lat);
      k = 0;
      while (k < WD + 20) begin
        idle(1);
        k++;
        if (wdog_trip === 1'b1) break;
      end
      check("wdog_idle_cycles", k, WD);
      idle(2);
      check("wdog_data_out", data_out, 16'h0000);
      wait_done(4*F + S + 3, lat); idle(1);
      check("wdog_active", active, 16'h0000);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
